reset_sequencer: RTL and testbench

//  Parametrised successor to the 2-FF reset synchroniser. Collects NUM_REQ active-low reset

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_sync_cell.sv | 25 ++
 rtl/reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_reset_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: state encoding, the
// asserted level of a domain reset, and the counter width rule.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      HOLD,
      RELEASE,
      RUN
   } state_t;

   localparam logic RST_ASSERTED = 1'b0;

   // Wide enough to reach the larger of the two count targets without wrapping.
   function automatic int cnt_width(input int min_assert, input int stage_gap);
      int m;
      m = (min_assert > stage_gap) ? min_assert : stage_gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Single-bit multi-flop synchroniser; the synchronous reset forces every
// stage to 0 so the cell reads as "fault" until fresh samples arrive.
module rst_sync_cell #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Synchronises reset requests and PLL lock, then releases the domain resets
// in order with programmable gaps. Optional macro RST_SEQ_CAUSE_EN adds
// sticky fault-cause reporting (rst_cause) and a fault counter (fault_cnt).
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int NUM_OUT     = 3,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_ASSERT  = 16,
   parameter int STAGE_GAP   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] rst_req_n,
   input  logic               locked,
   output logic [NUM_OUT-1:0] rst_out_n,
`ifdef RST_SEQ_CAUSE_EN
   output logic [NUM_REQ:0]   rst_cause,
   output logic [7:0]         fault_cnt,
`endif
   output logic               seq_done
);

   localparam int CNT_W = cnt_width(MIN_ASSERT, STAGE_GAP);
   localparam int IDX_W = $clog2(NUM_OUT + 1);

   // Bit NUM_REQ carries the lock input; 1 on every bit means "clean".
   logic [NUM_REQ:0] w_sync_n;
   logic             w_fault;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_sync
      rst_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .i_d (rst_req_n[i]),
         .o_q (w_sync_n[i])
      );
   end

   rst_sync_cell #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .i_d (locked),
      .o_q (w_sync_n[NUM_REQ])
   );

   assign w_fault = ~&w_sync_n;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [NUM_OUT-1:0] r_rst_out_n, w_rst_out_n_nxt;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_idx_nxt       = r_idx;
      w_rst_out_n_nxt = {NUM_OUT{RST_ASSERTED}};

      if (w_fault) begin
         w_state_nxt = HOLD;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            HOLD: begin
               if (r_cnt == CNT_W'(MIN_ASSERT - 1)) begin
                  w_state_nxt = RELEASE;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               // Stages up to and including idx are released; the output flop adds the cycle of lag.
               for (int k = 0; k < NUM_OUT; k++) begin
                  if (IDX_W'(k) <= r_idx) w_rst_out_n_nxt[k] = ~RST_ASSERTED;
               end
               if (r_idx == IDX_W'(NUM_OUT - 1)) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
               end else if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                  w_idx_nxt = r_idx + IDX_W'(1);
                  w_cnt_nxt = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            RUN: begin
               w_rst_out_n_nxt = {NUM_OUT{~RST_ASSERTED}};
            end
            default: begin
               w_state_nxt = HOLD;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= HOLD;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_rst_out_n <= {NUM_OUT{RST_ASSERTED}};
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_rst_out_n <= w_rst_out_n_nxt;
      end
   end

   assign rst_out_n = r_rst_out_n;
   assign seq_done  = (r_state == RUN);

`ifdef RST_SEQ_CAUSE_EN
   logic [NUM_REQ:0] r_cause;
   logic [7:0]       r_fault_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cause     <= '0;
         r_fault_cnt <= '0;
      end else begin
         if (w_fault) begin
            r_cause <= r_cause | ~w_sync_n;
         end else if (r_state == HOLD && w_state_nxt == RELEASE) begin
            r_cause <= '0;
         end
         // Only drops out of an active sequence count; faults while already holding do not.
         if (w_fault && r_state != HOLD && r_fault_cnt != 8'hFF) begin
            r_fault_cnt <= r_fault_cnt + 8'd1;
         end
      end
   end

   assign rst_cause = r_cause;
   assign fault_cnt = r_fault_cnt;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random
// fault/reset traffic against a clean-streak reference model.
module tb_reset_sequencer;

   localparam int NREQ = 2;
   localparam int NOUT = 3;
   localparam int SS   = 2;
   localparam int MA   = 16;
   localparam int GAP  = 8;

   logic            clk;
   logic            rst;
   logic [NREQ-1:0] rst_req_n;
   logic            locked;
   logic [NOUT-1:0] rst_out_n;
   logic            seq_done;
`ifdef RST_SEQ_CAUSE_EN
   logic [NREQ:0]   rst_cause;
   logic [7:0]      fault_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   reset_sequencer #(
      .NUM_REQ     (NREQ),
      .NUM_OUT     (NOUT),
      .SYNC_STAGES (SS),
      .MIN_ASSERT  (MA),
      .STAGE_GAP   (GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rst_req_n (rst_req_n),
      .locked    (locked),
      .rst_out_n (rst_out_n),
`ifdef RST_SEQ_CAUSE_EN
      .rst_cause (rst_cause),
      .fault_cnt (fault_cnt),
`endif
      .seq_done  (seq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: inputs reach the sequencer SS edges late; output k is
   // released once the run of consecutive clean edges reaches MA+1+k*GAP.
   logic [NREQ:0] m_pipe [SS];
   logic [NREQ:0] m_synced;
   int            m_s = 0;
   logic [NREQ:0] m_cause = '0;
   int            m_fcnt = 0;

   always @(posedge clk) begin
      m_synced = m_pipe[SS-1];
      if (rst) begin
         m_s     = 0;
         m_cause = '0;
         m_fcnt  = 0;
         for (int i = 0; i < SS; i++) m_pipe[i] = '0;
      end else begin
         if (&m_synced) begin
            if (m_s == MA - 1) m_cause = '0;
            m_s++;
         end else begin
            if (m_s >= MA && m_fcnt < 255) m_fcnt++;
            m_cause = m_cause | ~m_synced;
            m_s = 0;
         end
         for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = {locked, rst_req_n};
      end
   end

   function automatic logic [NOUT:0] exp_vec(input int s);
      logic [NOUT:0] v;
      for (int k = 0; k < NOUT; k++) v[k] = (s >= MA + 1 + k * GAP);
      v[NOUT] = (s >= MA + 1 + (NOUT - 1) * GAP);
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      rst_req_n = '1;
      locked    = 1'b1;
      repeat (5) tick();
      n_checks++;
      if ({seq_done, rst_out_n} !== '0)
         $display("FAIL reset_state: got %b expected %b", {seq_done, rst_out_n}, {(NOUT+1){1'b0}});
      else n_pass++;
   endtask

   task automatic test_power_up();
      int rise [NOUT+1];
      int exp_e;
      for (int k = 0; k <= NOUT; k++) rise[k] = -1;
      rst = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         tick();
         n_checks++;
         if ({seq_done, rst_out_n} !== exp_vec(m_s))
            $display("FAIL power_up_model edge %0d: got %b expected %b", e, {seq_done, rst_out_n}, exp_vec(m_s));
         else n_pass++;
         for (int k = 0; k <= NOUT; k++)
            if (rise[k] < 0 && {seq_done, rst_out_n}[k]) rise[k] = e;
      end
      for (int k = 0; k <= NOUT; k++) begin
         exp_e = SS + MA + 1 + ((k == NOUT) ? NOUT - 1 : k) * GAP;
         n_checks++;
         if (rise[k] !== exp_e)
            $display("FAIL power_up_rise bit %0d: got edge %0d expected edge %0d", k, rise[k], exp_e);
         else n_pass++;
      end
   endtask

   task automatic test_short_fault();
      int rise0 = -1;
      rst_req_n[1] = 1'b0;
      tick();
      rst_req_n[1] = 1'b1;
      for (int t = 2; t <= 45; t++) begin
         tick();
         if (t == SS + 1) begin
            n_checks++;
            if ({seq_done, rst_out_n} !== '0)
               $display("FAIL short_fault_assert: got %b expected %b", {seq_done, rst_out_n}, {(NOUT+1){1'b0}});
            else n_pass++;
         end
         n_checks++;
         if ({seq_done, rst_out_n} !== exp_vec(m_s))
            $display("FAIL short_fault_model t=%0d: got %b expected %b", t, {seq_done, rst_out_n}, exp_vec(m_s));
         else n_pass++;
         if (rise0 < 0 && t > SS + 1 && rst_out_n[0]) rise0 = t;
      end
      n_checks++;
      if (rise0 !== 2 + SS + MA)
         $display("FAIL short_fault_rerelease: got t=%0d expected t=%0d", rise0, 2 + SS + MA);
      else n_pass++;
   endtask

   task automatic test_hold_restart();
      int rise0 = -1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (12) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         n_checks++;
         if ({seq_done, rst_out_n} !== exp_vec(m_s))
            $display("FAIL hold_restart_model t=%0d: got %b expected %b", t, {seq_done, rst_out_n}, exp_vec(m_s));
         else n_pass++;
         if (rise0 < 0 && rst_out_n[0]) rise0 = t;
      end
      n_checks++;
      if (rise0 !== MA + SS + 1)
         $display("FAIL hold_restart_rise: got t=%0d expected t=%0d", rise0, MA + SS + 1);
      else n_pass++;
   endtask

   task automatic test_partial_fault();
      bit found = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 40 && !found; e++) begin
         tick();
         if (rst_out_n[0]) found = 1;
      end
      n_checks++;
      if (!found) $display("FAIL partial_fault_first_release: got no rise expected rise within 40 edges");
      else n_pass++;
      repeat (2) tick();
      rst_req_n[0] = 1'b0;
      tick();
      rst_req_n[0] = 1'b1;
      repeat (SS) tick();
      n_checks++;
      if ({seq_done, rst_out_n} !== '0)
         $display("FAIL partial_fault_reassert: got %b expected %b", {seq_done, rst_out_n}, {(NOUT+1){1'b0}});
      else n_pass++;
      for (int t = 1; t <= 45; t++) begin
         tick();
         if (t <= 15) begin
            n_checks++;
            if (rst_out_n[NOUT-1:1] !== '0)
               $display("FAIL partial_fault_later_stages t=%0d: got %b expected 0", t, rst_out_n[NOUT-1:1]);
            else n_pass++;
         end
         n_checks++;
         if ({seq_done, rst_out_n} !== exp_vec(m_s))
            $display("FAIL partial_fault_model t=%0d: got %b expected %b", t, {seq_done, rst_out_n}, exp_vec(m_s));
         else n_pass++;
      end
   endtask

   task automatic test_rst_in_run();
      int rise [NOUT+1];
      n_checks++;
      if (seq_done !== 1'b1) $display("FAIL rst_in_run_precond: got seq_done=%b expected 1", seq_done);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++;
      if ({seq_done, rst_out_n} !== '0)
         $display("FAIL rst_in_run_assert: got %b expected %b", {seq_done, rst_out_n}, {(NOUT+1){1'b0}});
      else n_pass++;
      tick();
      rst = 1'b0;
      for (int k = 0; k <= NOUT; k++) rise[k] = -1;
      for (int e = 1; e <= 40; e++) begin
         tick();
         for (int k = 0; k <= NOUT; k++)
            if (rise[k] < 0 && {seq_done, rst_out_n}[k]) rise[k] = e;
      end
      for (int k = 0; k <= NOUT; k++) begin
         n_checks++;
         if (rise[k] !== SS + MA + 1 + ((k == NOUT) ? NOUT - 1 : k) * GAP)
            $display("FAIL rst_in_run_rise bit %0d: got edge %0d expected edge %0d", k, rise[k],
                     SS + MA + 1 + ((k == NOUT) ? NOUT - 1 : k) * GAP);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int            left = 0;
      int            r;
      logic [NREQ:0] mask;
      for (int c = 0; c < 3000; c++) begin
         if (left == 0) begin
            r         = int'($urandom_range(0, 99));
            rst       = 1'b0;
            rst_req_n = '1;
            locked    = 1'b1;
            if (r < 3) begin
               rst  = 1'b1;
               left = int'($urandom_range(1, 3));
            end else if (r < 10) begin
               mask = (NREQ+1)'($urandom_range(1, (1 << (NREQ + 1)) - 1));
               {locked, rst_req_n} = ~mask;
               left = int'($urandom_range(1, 4));
            end else begin
               left = int'($urandom_range(1, 60));
            end
         end
         left--;
         tick();
         n_checks++;
         if ({seq_done, rst_out_n} !== exp_vec(m_s))
            $display("FAIL random_model cycle %0d: got %b expected %b", c, {seq_done, rst_out_n}, exp_vec(m_s));
         else n_pass++;
`ifdef RST_SEQ_CAUSE_EN
         n_checks++;
         if (rst_cause !== m_cause || fault_cnt !== 8'(m_fcnt))
            $display("FAIL random_cause cycle %0d: got %b/%0d expected %b/%0d", c, rst_cause, fault_cnt, m_cause, m_fcnt);
         else n_pass++;
`endif
      end
      rst       = 1'b0;
      rst_req_n = '1;
      locked    = 1'b1;
   endtask

`ifdef RST_SEQ_CAUSE_EN
   task automatic test_cause();
      bit            found = 0;
      logic [NREQ:0] exp_cause;
      exp_cause          = '0;
      exp_cause[0]       = 1'b1;
      exp_cause[NREQ]    = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (40) tick();
      n_checks++;
      if (fault_cnt !== 8'd0 || seq_done !== 1'b1)
         $display("FAIL cause_precond: got cnt=%0d done=%b expected cnt=0 done=1", fault_cnt, seq_done);
      else n_pass++;
      rst_req_n[0] = 1'b0;
      tick();
      locked = 1'b0;
      tick();
      rst_req_n[0] = 1'b1;
      tick();
      locked = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (rst_cause !== exp_cause || fault_cnt !== 8'd1)
         $display("FAIL cause_latched: got %b/%0d expected %b/1", rst_cause, fault_cnt, exp_cause);
      else n_pass++;
      for (int e = 1; e <= 40 && !found; e++) begin
         tick();
         if (rst_out_n[0]) found = 1;
      end
      n_checks++;
      if (!found || rst_cause !== '0 || fault_cnt !== 8'd1)
         $display("FAIL cause_cleared: got found=%b cause=%b cnt=%0d expected 1/0/1", found, rst_cause, fault_cnt);
      else n_pass++;
   endtask
`endif

   initial begin
      rst       = 1'b1;
      rst_req_n = '1;
      locked    = 1'b1;
      test_reset();
      test_power_up();
      test_short_fault();
      test_hold_restart();
      test_partial_fault();
      test_rst_in_run();
`ifdef RST_SEQ_CAUSE_EN
      test_cause();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
